// File: rtl/display_mux_14seg_pkg.sv
// Shared types and helpers for the 14-segment display scan controller.
package disp14_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // ASCII space: what an empty or dark digit presents to the decoder.
  localparam logic [7:0] SPACE_CODE = 8'd32;

  // Clock cycles per digit slot.
  function automatic int calc_period(input int clock_hz, input int digit_hz);
    return clock_hz / digit_hz;
  endfunction

endpackage

// File: rtl/display_mux_14seg_if.sv
// Character write port into the display buffer.
interface display_mux_14seg_if #(
  parameter int AW = 2
);
  logic          strobe;
  logic [AW-1:0] addr;
  logic [7:0]    data;

  modport master (output strobe, addr, data);
  modport slave  (input  strobe, addr, data);
endinterface

// File: rtl/display_mux_14seg_prescaler.sv
// Slot counter: runs 0..PERIOD-1 while scanning and flags the end of the
// blanking gap and the end of the whole slot.
module scan_prescaler #(
  parameter int PERIOD       = 10,
  parameter int BLANK_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic blank_end,
  output logic slot_end
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] count;

  assign blank_end = (count == CW'(BLANK_CYCLES - 1));
  assign slot_end  = (count == CW'(PERIOD - 1));

  // Held at zero while not scanning so the first slot always starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!run || slot_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/display_mux_14seg.sv
// Time-multiplexed scan controller for a multi-digit 14-segment display.
// Holds one character per digit, steps through the digits with a blanking
// gap ahead of each one, and feeds the shared decoder.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | display dark, waiting for enable
//   BLANK | all digits off, decoder gets the upcoming digit's code
//   SHOW  | selected digit on, decoder enabled
module display_mux_14seg
  import disp14_pkg::*;
#(
  parameter int CLOCK_HZ          = 25_000_000,
  parameter int DIGIT_HZ          = 1_000,
  parameter int DIGITS            = 4,
  parameter int BLANK_CYCLES      = 16,
  parameter bit DIGIT_ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  display_mux_14seg_if.slave    wr,
  output logic [7:0]            char_code,
  output logic                  char_enable,
  output logic [DIGITS-1:0]     digit,
  output logic                  frame_done
);

  localparam int PERIOD = calc_period(CLOCK_HZ, DIGIT_HZ);
  localparam int AW     = $clog2(DIGITS);

  // XOR mask turning an active-high one-hot select into the pin polarity;
  // also the value of the digit pins when everything is off.
  localparam logic [DIGITS-1:0] DIGIT_OFF = DIGIT_ACTIVE_HIGH ? '0 : '1;

  if (PERIOD < 2) begin : g_bad_period
    $error("display_mux_14seg: PERIOD must be at least 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PERIOD) begin : g_bad_blank
    $error("display_mux_14seg: BLANK_CYCLES must be in 1..PERIOD-1");
  end
  if (DIGITS < 2 || DIGITS > 16) begin : g_bad_digits
    $error("display_mux_14seg: DIGITS must be in 2..16");
  end

  state_t          state, next_state;
  logic [AW-1:0]   idx, next_idx;
  logic            wrap;
  logic [7:0]      char_buf [DIGITS];
  logic            wr_hit;
  logic [7:0]      rd_next;
  logic [DIGITS-1:0] sel_next;
  logic            run;
  logic            blank_end;
  logic            slot_end;

  assign run    = (state != IDLE) && enable;
  assign wr_hit = wr.strobe && (int'(wr.addr) < DIGITS);

  scan_prescaler #(
    .PERIOD       (PERIOD),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  // Next state, next digit index and the frame-wrap event.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    wrap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          next_state = BLANK;
          next_idx   = '0;
        end
      end
      BLANK: begin
        if (blank_end) next_state = SHOW;
      end
      SHOW: begin
        if (slot_end) begin
          next_state = BLANK;
          if (idx == AW'(DIGITS - 1)) begin
            next_idx = '0;
            wrap     = 1'b1;
          end else begin
            next_idx = idx + 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    if (!enable) begin
      next_state = IDLE;
      next_idx   = '0;
      wrap       = 1'b0;
    end
  end

  // Code the decoder will see next cycle; a same-cycle write bypasses the
  // buffer so an update to the lit digit appears without a slot restart.
  always_comb begin
    rd_next = char_buf[next_idx];
    if (wr_hit && (wr.addr == next_idx)) rd_next = wr.data;
  end

  // One-hot select for the upcoming cycle, active-high before polarity.
  always_comb begin
    sel_next = '0;
    if (next_state == SHOW) sel_next[next_idx] = 1'b1;
  end

  // Character buffer; writes are accepted in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) char_buf[i] <= SPACE_CODE;
    end else if (wr_hit) begin
      char_buf[wr.addr] <= wr.data;
    end
  end

  // State register and registered outputs, all derived from the next state
  // so that outputs and state change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      char_code   <= SPACE_CODE;
      char_enable <= 1'b0;
      digit       <= DIGIT_OFF;
      frame_done  <= 1'b0;
    end else begin
      state       <= next_state;
      idx         <= next_idx;
      char_code   <= (next_state == IDLE) ? SPACE_CODE : rd_next;
      char_enable <= (next_state == SHOW);
      digit       <= sel_next ^ DIGIT_OFF;
      frame_done  <= wrap;
    end
  end

endmodule

// File: tb/tb_display_mux_14seg.sv
// Bench for display_mux_14seg: two instances (4 digits active-high, 3 digits
// active-low) compared each cycle against a time-based reference model.
module tb_display_mux_14seg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;

  logic [7:0] char_a, char_b;
  logic       cen_a, cen_b, fd_a, fd_b;
  logic [3:0] dig_a;
  logic [2:0] dig_b;

  int errors = 0;
  int checks = 0;

  display_mux_14seg_if #(.AW(2)) ifa ();
  display_mux_14seg_if #(.AW(2)) ifb ();

  display_mux_14seg #(
    .CLOCK_HZ(1000), .DIGIT_HZ(100), .DIGITS(4), .BLANK_CYCLES(2), .DIGIT_ACTIVE_HIGH(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .wr(ifa),
    .char_code(char_a), .char_enable(cen_a), .digit(dig_a), .frame_done(fd_a)
  );

  display_mux_14seg #(
    .CLOCK_HZ(1000), .DIGIT_HZ(100), .DIGITS(3), .BLANK_CYCLES(2), .DIGIT_ACTIVE_HIGH(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .wr(ifb),
    .char_code(char_b), .char_enable(cen_b), .digit(dig_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  // Reference model: t counts cycles since scanning began; a slot is 10 cycles,
  // the first 2 of which are dark.
  bit         a_run, b_run;
  int         a_t, b_t;
  logic [7:0] a_mem [4];
  logic [7:0] b_mem [3];
  logic [7:0] ea_char, eb_char;
  logic       ea_cen, eb_cen, ea_fd, eb_fd;
  logic [3:0] ea_dig;
  logic [2:0] eb_dig;

  task automatic model_reset();
    a_run = 0; b_run = 0; a_t = 0; b_t = 0;
    foreach (a_mem[i]) a_mem[i] = 8'd32;
    foreach (b_mem[i]) b_mem[i] = 8'd32;
  endtask

  task automatic model_outputs();
    int d;
    if (!a_run) begin
      ea_char = 8'd32; ea_cen = 0; ea_dig = 4'b0000; ea_fd = 0;
    end else begin
      d = (a_t / 10) % 4;
      ea_char = a_mem[d];
      ea_cen = (a_t % 10) >= 2;
      ea_dig = ea_cen ? 4'(1 << d) : 4'b0000;
      ea_fd = (a_t > 0) && (a_t % 40 == 0);
    end
    if (!b_run) begin
      eb_char = 8'd32; eb_cen = 0; eb_dig = 3'b111; eb_fd = 0;
    end else begin
      d = (b_t / 10) % 3;
      eb_char = b_mem[d];
      eb_cen = (b_t % 10) >= 2;
      eb_dig = ~(eb_cen ? 3'(1 << d) : 3'b000);
      eb_fd = (b_t > 0) && (b_t % 30 == 0);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ifa.strobe) a_mem[ifa.addr] = ifa.data;
      if (ifb.strobe && ifb.addr < 3) b_mem[ifb.addr] = ifb.data;
      if (!en_a) a_run = 0;
      else if (!a_run) begin a_run = 1; a_t = 0; end
      else a_t++;
      if (!en_b) b_run = 0;
      else if (!b_run) begin b_run = 1; b_t = 0; end
      else b_t++;
    end
    model_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    ifa.strobe = 0; ifa.addr = '0; ifa.data = '0;
    ifb.strobe = 0; ifb.addr = '0; ifb.data = '0;
    rst_n = 0;
    model_reset();
    model_outputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({char_a, cen_a, dig_a, fd_a} !== {ea_char, ea_cen, ea_dig, ea_fd}) begin
        errors++;
        $display("FAIL reset_idle_a cyc=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 i, char_a, cen_a, dig_a, fd_a, ea_char, ea_cen, ea_dig, ea_fd);
      end
      checks++;
      if ({char_b, cen_b, dig_b, fd_b} !== {eb_char, eb_cen, eb_dig, eb_fd}) begin
        errors++;
        $display("FAIL reset_idle_b cyc=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 i, char_b, cen_b, dig_b, fd_b, eb_char, eb_cen, eb_dig, eb_fd);
      end
    end
  endtask

  task automatic test_scan();
    int fd_count = 0;
    for (int i = 0; i < 4; i++) begin
      ifa.strobe = 1; ifa.addr = 2'(i); ifa.data = 8'(65 + i);
      tick();
    end
    ifa.strobe = 0;
    en_a = 1;
    for (int i = 0; i < 125; i++) begin
      tick();
      if (fd_a === 1'b1) fd_count++;
      checks++;
      if ({char_a, cen_a, dig_a, fd_a} !== {ea_char, ea_cen, ea_dig, ea_fd}) begin
        errors++;
        $display("FAIL scan t=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 a_t, char_a, cen_a, dig_a, fd_a, ea_char, ea_cen, ea_dig, ea_fd);
      end
    end
    checks++;
    if (fd_count != 3) begin
      errors++;
      $display("FAIL frame_count got %0d want 3", fd_count);
    end
  endtask

  task automatic test_midslot_write();
    int guard = 0;
    while (a_t % 40 != 15 && guard < 100) begin tick(); guard++; end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL midslot_reach got timeout want digit1 show");
    end
    ifa.strobe = 1; ifa.addr = 2'd1; ifa.data = 8'd90;
    tick();
    ifa.strobe = 0;
    checks++;
    if (char_a !== 8'd90 || dig_a !== 4'b0010 || cen_a !== 1'b1) begin
      errors++;
      $display("FAIL midslot_write got char=%0d dig=%b en=%b want char=90 dig=0010 en=1",
               char_a, dig_a, cen_a);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if ({char_a, cen_a, dig_a, fd_a} !== {ea_char, ea_cen, ea_dig, ea_fd}) begin
        errors++;
        $display("FAIL midslot_follow t=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 a_t, char_a, cen_a, dig_a, fd_a, ea_char, ea_cen, ea_dig, ea_fd);
      end
    end
  endtask

  task automatic test_enable_drop();
    int guard = 0;
    while (a_t % 40 != 25 && guard < 100) begin tick(); guard++; end
    en_a = 0;
    tick();
    checks++;
    if (dig_a !== 4'b0000 || cen_a !== 1'b0 || char_a !== 8'd32) begin
      errors++;
      $display("FAIL enable_drop got dig=%b en=%b char=%0d want dig=0000 en=0 char=32",
               dig_a, cen_a, char_a);
    end
    repeat (3) tick();
    en_a = 1;
    for (int i = 0; i < 45; i++) begin
      tick();
      checks++;
      if ({char_a, cen_a, dig_a, fd_a} !== {ea_char, ea_cen, ea_dig, ea_fd}) begin
        errors++;
        $display("FAIL reenable t=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 a_t, char_a, cen_a, dig_a, fd_a, ea_char, ea_cen, ea_dig, ea_fd);
      end
    end
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      en_a = ($urandom_range(0, 39) != 0);
      ifa.strobe = ($urandom_range(0, 3) == 0);
      ifa.addr = 2'($urandom_range(0, 3));
      ifa.data = 8'($urandom_range(0, 255));
      tick();
      checks++;
      if ({char_a, cen_a, dig_a, fd_a} !== {ea_char, ea_cen, ea_dig, ea_fd}) begin
        errors++;
        $display("FAIL random i=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 i, char_a, cen_a, dig_a, fd_a, ea_char, ea_cen, ea_dig, ea_fd);
      end
    end
    ifa.strobe = 0;
    en_a = 1;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(a_run && a_t % 40 == 32) && guard < 100) begin tick(); guard++; end
    #2 rst_n = 0;
    model_reset();
    model_outputs();
    #1;
    checks++;
    if (char_a !== 8'd32 || cen_a !== 1'b0 || dig_a !== 4'b0000 || fd_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got char=%0d en=%b dig=%b fd=%b want char=32 en=0 dig=0000 fd=0",
               char_a, cen_a, dig_a, fd_a);
    end
    #1 rst_n = 1;
    for (int i = 0; i < 45; i++) begin
      tick();
      checks++;
      if ({char_a, cen_a, dig_a, fd_a} !== {ea_char, ea_cen, ea_dig, ea_fd}) begin
        errors++;
        $display("FAIL post_reset t=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 a_t, char_a, cen_a, dig_a, fd_a, ea_char, ea_cen, ea_dig, ea_fd);
      end
    end
  endtask

  task automatic test_active_low_3digit();
    checks++;
    if (dig_b !== 3'b111) begin
      errors++;
      $display("FAIL b_idle_digits got %b want 111", dig_b);
    end
    for (int i = 0; i < 4; i++) begin
      ifb.strobe = 1; ifb.addr = 2'(i); ifb.data = 8'($urandom_range(33, 126));
      tick();
    end
    ifb.strobe = 0;
    en_b = 1;
    repeat (3) tick();
    checks++;
    if (dig_b !== 3'b110 || cen_b !== 1'b1) begin
      errors++;
      $display("FAIL b_digit0_active got dig=%b en=%b want dig=110 en=1", dig_b, cen_b);
    end
    for (int i = 0; i < 95; i++) begin
      ifb.strobe = (i % 7 == 3);
      ifb.addr = (i % 14 == 3) ? 2'd3 : 2'($urandom_range(0, 3));
      ifb.data = 8'($urandom_range(0, 255));
      tick();
      checks++;
      if ({char_b, cen_b, dig_b, fd_b} !== {eb_char, eb_cen, eb_dig, eb_fd}) begin
        errors++;
        $display("FAIL b_scan t=%0d got char=%0d en=%b dig=%b fd=%b want char=%0d en=%b dig=%b fd=%b",
                 b_t, char_b, cen_b, dig_b, fd_b, eb_char, eb_cen, eb_dig, eb_fd);
      end
    end
    ifb.strobe = 0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midslot_write();
    test_enable_drop();
    test_random_traffic();
    test_async_reset();
    test_active_low_3digit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
